pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DBITS, default 32: width of one data word.
REQ-002 Parameter NDATA, default 4: number of data words carried per beat.
REQ-003 Parameter NCTRL, default 4: number of control bits carried per beat.
REQ-004 Parameter KILL_MASK, default 4'b1011: control bits forced to 0 whenever out_valid=0.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 flush  in  1  kill all held and incoming beats this cycle.
REQ-008 in_valid  in  1  upstream beat present.
REQ-009 in_ready  out  1  stage can accept a beat.
REQ-010 in_ctrl  in  NCTRL  upstream control bits.
REQ-011 in_data  in  NDATA*DBITS  upstream data; word k occupies bits [k*DBITS +: DBITS].
REQ-012 out_valid  out  1  downstream beat present.
REQ-013 out_ready  in  1  downstream accepts the beat.
REQ-014 out_ctrl  out  NCTRL  held control bits, masked per REQ-020.
REQ-015 out_data  out  NDATA*DBITS  held data.

Function
REQ-016 A beat transfers in when in_valid & in_ready, and out when out_valid & out_ready, at the rising edge.
REQ-017 Latency is one cycle: a beat accepted at edge N appears on out_* after edge N, when the stage was empty or draining.
REQ-018 Beat order is preserved; no beat is duplicated or dropped except by flush.
REQ-019 Data and control bits pass unmodified; widths are exactly as declared, with no truncation.
REQ-020 out_ctrl[i] is 0 whenever out_valid=0 and KILL_MASK[i]=1; bits with KILL_MASK[i]=0 hold their last value.
REQ-021 Flush has top priority: the next state is EMPTY, out_valid=0, and any beat offered in the same cycle is dropped, regardless of in_ready or out_ready.
REQ-022 Held out_data/out_ctrl stay stable while out_valid=1 and out_ready=0.
REQ-023 Without skid, the state machine is EMPTY/FULL.
REQ-024 Without skid, in_ready = ~out_valid | out_ready (combinational).
REQ-025 Without skid, FULL with a simultaneous accept and drain stays FULL with the new beat.

Reset
REQ-026 While reset_n=0 at an edge: state EMPTY, out_valid=0, out_ctrl=0, out_data=0.
REQ-027 After reset, in_ready=1.
REQ-028 Reset overrides flush and all handshakes; a beat offered during reset is dropped.

Configuration
REQ-029 The macro PIPE_STAGE_SKID_EN, when defined, adds a one-entry skid buffer and gives the states EMPTY, ONE and TWO.
REQ-030 With PIPE_STAGE_SKID_EN, in_ready is registered and equals 1 exactly when the state is not TWO.
REQ-031 With PIPE_STAGE_SKID_EN, transitions: EMPTY+in -> ONE; ONE+in&~out_ready -> TWO (beat to skid); ONE+in&out_ready -> ONE; ONE+~in&out_ready -> EMPTY; TWO+out_ready -> ONE (skid promoted to output, in_ready=1 next cycle).
REQ-032 With PIPE_STAGE_SKID_EN, in_ready has no combinational path from out_ready.
REQ-033 Without PIPE_STAGE_SKID_EN, the behaviour is REQ-023..025 and no skid storage exists.

Verification
REQ-034 Reset with reset_n=0 for 2 cycles -> out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
REQ-035 Stream 8 beats with data 0x1..0x8 and out_ready=1 -> outputs 0x1..0x8 in order at one per cycle, each one cycle after input.
REQ-036 Skid build: accept 0xA, hold out_ready=0, offer 0xB then 0xC -> 0xB enters the skid, in_ready=0, and 0xC waits; raise out_ready -> 0xA, 0xB, 0xC in order.
REQ-037 Skid flush: flush=1 in state TWO with in_valid=1 -> next cycle out_valid=0, out_ctrl=(last ctrl & ~KILL_MASK), in_ready=1, and no earlier beat reappears.
REQ-038 Reset mid-stream: reset_n=0 while FULL with out_ready=0 -> state EMPTY, all outputs 0; the next accepted beat 0x5 emerges alone.
REQ-039 Configuration: rerun REQ-035..038 both with and without PIPE_STAGE_SKID_EN -> order, flush and reset results identical; without the macro, in_ready follows out_ready in the same cycle.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// One-beat pipeline register between a valid/ready producer and consumer.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg #(
    parameter int               DBITS     = 32,
    parameter int               NDATA     = 4,
    parameter int               NCTRL     = 4,
    parameter logic [NCTRL-1:0] KILL_MASK = 4'b1011
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NCTRL-1:0]       in_ctrl,
    input  logic [NDATA*DBITS-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NCTRL-1:0]       out_ctrl,
    output logic [NDATA*DBITS-1:0] out_data,
    output logic [1:0]             dbg_state_o
);

    localparam int DW = NDATA * DBITS;

    // Handshake: a beat moves on a rising edge only when valid and ready are both
    // high on that side; valid never depends on ready, and flush or reset cancels it.

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [DW-1:0]    data_q, data_d;
    logic [NCTRL-1:0] ctrl_q, ctrl_d;
    logic             accept;

    assign out_valid   = (state_q != S_EMPTY);
    assign out_data    = data_q;
    assign out_ctrl    = out_valid ? ctrl_q : (ctrl_q & ~KILL_MASK);
    assign dbg_state_o = state_q;

`ifdef PIPE_STAGE_SKID_EN
    logic [DW-1:0]    skid_data_q, skid_data_d;
    logic [NCTRL-1:0] skid_ctrl_q, skid_ctrl_d;
    logic             in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
    assign accept   = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        ctrl_d      = ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        state_d = S_ONE;
                        data_d  = in_data;
                        ctrl_d  = in_ctrl;
                    end
                end
                S_ONE: begin
                    if (accept && out_ready) begin
                        data_d = in_data;
                        ctrl_d = in_ctrl;
                    end else if (accept) begin
                        state_d     = S_TWO;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_ready) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so only the skid entry can move forward.
                    if (out_ready) begin
                        state_d = S_ONE;
                        data_d  = skid_data_q;
                        ctrl_d  = skid_ctrl_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_EMPTY;
            data_q      <= '0;
            ctrl_q      <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            ctrl_q      <= ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end
`else
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            // Covers both filling an empty stage and replacing a draining beat.
            state_d = S_FULL;
            data_d  = in_data;
            ctrl_d  = in_ctrl;
        end else if (out_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed beats, a monitor popping expected beats.
// Runs in both builds; skid-only expectations are selected by PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    localparam int         DBITS = 32;
    localparam int         NDATA = 4;
    localparam int         NCTRL = 4;
    localparam int         DW    = NDATA * DBITS;
    localparam int         W     = NCTRL + DW;
    localparam logic [3:0] KM    = 4'b1011;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    dbg_state;

    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           n_out  = 0;

    pipe_stage_reg #(.DBITS(DBITS), .NDATA(NDATA), .NCTRL(NCTRL), .KILL_MASK(KM)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ctrl     (in_ctrl),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_data    (out_data),
        .dbg_state_o (dbg_state)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // word k carries k in its top nibble and v in its low byte
    function automatic logic [DW-1:0] mk_data(input logic [7:0] v);
        logic [DW-1:0] d;
        for (int k = 0; k < NDATA; k++)
            d[k*DBITS +: DBITS] = (32'(k) << 28) | 32'(v);
        return d;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: offer one beat until accepted, push its expected output on acceptance
    task automatic send(input logic [7:0] v, input logic [3:0] c);
        logic rdy;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = mk_data(v);
        in_ctrl  = c;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            rdy = in_ready && reset_n && !flush;
            @(posedge clk);
            if (rdy) begin
                exp_q.push_back({c, mk_data(v)});
                done = 1'b1;
                break;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %h got no in_ready, required acceptance", v);
        end
    endtask

    // scoreboard monitor
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_val   = '0;
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (prev_stall && out_valid)
                chk("stable_while_stalled", {out_ctrl, out_data}, prev_val);
            if (reset_n && !flush && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %h expected no beat", {out_ctrl, out_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {out_ctrl, out_data}, e);
                    n_out++;
                end
            end
            prev_stall = reset_n && !flush && out_valid && !out_ready;
            prev_val   = {out_ctrl, out_data};
        end
    end

    initial begin
        int n0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = mk_data(8'hEE);
        in_ctrl   = 4'hF;

        // reset for two cycles with a beat offered; it must be dropped
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", W'(out_valid), W'(0));
        chk("reset_out_ctrl", W'(out_ctrl), W'(0));
        chk("reset_out_data", W'(out_data), W'(0));
        in_valid = 1'b0;
        reset_n  = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", W'(in_ready), W'(1));
        chk("reset_state", W'(dbg_state), W'(0));

        // stream 8 beats at full rate, each visible one cycle after acceptance
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = mk_data(8'(i));
            in_ctrl  = 4'(i);
            @(negedge clk);
            chk("stream_in_ready", W'(in_ready), W'(1));
            @(posedge clk);
            exp_q.push_back({4'(i), mk_data(8'(i))});
            #1;
            chk("stream_out_valid", W'(out_valid), W'(1));
            chk("stream_word0", W'(out_data[31:0]), W'(i));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stream_drained", W'(out_valid), W'(0));

        // stall with 0xA held, offer 0xB and 0xC, then release
        out_ready = 1'b0;
        fork
            begin
                send(8'h0A, 4'hF);
                send(8'h0B, 4'h2);
                send(8'h0C, 4'h3);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                chk("skid_in_ready_low", W'(in_ready), W'(0));
                chk("skid_head", W'(out_data[31:0]), W'(8'h0A));
`ifdef PIPE_STAGE_SKID_EN
                chk("skid_state_two", W'(dbg_state), W'(2));
                out_ready = 1'b1;
                #1;
                chk("skid_no_comb_ready", W'(in_ready), W'(0));
`else
                out_ready = 1'b1;
                #1;
                chk("comb_ready_follows", W'(in_ready), W'(1));
`endif
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("skid_all_drained", W'(exp_q.size()), W'(0));

        // flush with the stage full (and skid full when present) and a beat offered
        out_ready = 1'b0;
        send(8'h11, 4'hF);
        in_valid = 1'b1;
        in_data  = mk_data(8'h12);
        in_ctrl  = 4'h1;
        @(posedge clk);
        #1;
        flush   = 1'b1;
        in_data = mk_data(8'h13);
        in_ctrl = 4'h2;
        @(posedge clk);
        exp_q.delete();
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", W'(out_valid), W'(0));
        chk("flush_out_ctrl", W'(out_ctrl), W'(4'b0100));
        chk("flush_in_ready", W'(in_ready), W'(1));
        chk("flush_state", W'(dbg_state), W'(0));
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_reappear", W'(out_valid), W'(0));

        // reset while full and stalled, then a single beat 0x5
        out_ready = 1'b0;
        send(8'h21, 4'h9);
        in_valid = 1'b1;
        in_data  = mk_data(8'h22);
        in_ctrl  = 4'h6;
        reset_n  = 1'b0;
        @(posedge clk);
        exp_q.delete();
        #1;
        in_valid = 1'b0;
        chk("midreset_out_valid", W'(out_valid), W'(0));
        chk("midreset_out_ctrl", W'(out_ctrl), W'(0));
        chk("midreset_out_data", W'(out_data), W'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_in_ready", W'(in_ready), W'(1));
        n0        = n_out;
        out_ready = 1'b1;
        send(8'h05, 4'h5);
        repeat (4) @(posedge clk);
        #1;
        chk("midreset_single_beat", W'(n_out - n0), W'(1));
        chk("final_queue_empty", W'(exp_q.size()), W'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
